// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag-vector bit positions for the registered ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_ADDC = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SUBC = 4'd7;
    localparam logic [3:0] OP_CMP  = 4'd8;
    localparam logic [3:0] OP_TEST = 4'd9;
    localparam logic [3:0] OP_LSH  = 4'd10;
    localparam logic [3:0] OP_RSH  = 4'd11;
    localparam logic [3:0] OP_ARSH = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLG_C = 0;
    localparam int FLG_F = 1;
    localparam int FLG_L = 2;
    localparam int FLG_N = 3;
    localparam int FLG_Z = 4;
    localparam int FLG_W = 5;

endpackage

// File: rtl/alu_if.sv
// Request/response bundle between the register-file read side and the ALU.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic             InValid;
    logic             InReady;
    logic [3:0]       Opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CarryIn;
    logic             OutValid;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic             Carry;
    logic             Flag;
    logic             Low;
    logic             Negative;
    logic             Zero;

    modport master (
        output InValid, Opcode, A, B, CarryIn,
        input  InReady, OutValid, Result, ResultHi, Carry, Flag, Low, Negative, Zero
    );

    modport slave (
        input  InValid, Opcode, A, B, CarryIn,
        output InReady, OutValid, Result, ResultHi, Carry, Flag, Low, Negative, Zero
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   psum;

    // Low half holds the remaining multiplier bits; high half accumulates.
    assign psum = {1'b0, product[2*WIDTH-1:WIDTH]}
                + (product[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    // High during the final iteration; product is complete from the next cycle.
    assign done = busy && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            mcand   <= A;
            product <= {{WIDTH{1'b0}}, B};
        end else if (busy) begin
            product <= {psum, product[WIDTH-1:1]};
            cnt     <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with valid/ready input and one-cycle OutValid pulse.
// Define ALU_MUL_EN to build the iterative MUL path (otherwise MUL decodes as undefined).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic reset_n,
    alu_if.slave bus
);
    localparam int               SHAMT_W = $clog2(WIDTH);
    localparam int               M       = WIDTH - 1;
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    logic [WIDTH-1:0] res, res_hi;
    logic [FLG_W-1:0] flg;
    logic             ovld;
    logic             accept;

    logic [WIDTH-1:0] nx_res, nx_hi, zsrc;
    logic [FLG_W-1:0] nx_flg;
    logic             nx_wr, zen;

    logic               add_cin, sub_cin, add_ovf, sub_ovf;
    logic [WIDTH:0]     add_x, sub_x, lsh_x, rsh_x;
    logic signed [WIDTH:0] ash_x;
    logic [SHAMT_W:0]   sh_amt;

    assign add_cin = (bus.Opcode == OP_ADDC) & bus.CarryIn;
    assign sub_cin = (bus.Opcode == OP_SUBC) & bus.CarryIn;
    assign add_x   = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, add_cin};
    assign sub_x   = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, sub_cin};
    assign add_ovf = (bus.A[M] == bus.B[M]) && (add_x[M] != bus.A[M]);
    assign sub_ovf = (bus.A[M] != bus.B[M]) && (sub_x[M] != bus.A[M]);

    // Amounts past WIDTH clamp to WIDTH+1 so the extra carry bit is shifted out too.
    assign sh_amt = (bus.B > WIDTH_V) ? (SHAMT_W+1)'(WIDTH + 1) : bus.B[SHAMT_W:0];
    assign lsh_x  = {1'b0, bus.A} << sh_amt;
    assign rsh_x  = {bus.A, 1'b0} >> sh_amt;
    assign ash_x  = $signed({bus.A, 1'b0}) >>> sh_amt;

    always_comb begin
        nx_res = '0;
        nx_hi  = '0;
        nx_flg = '0;
        nx_wr  = 1'b1;
        zen    = 1'b1;
        zsrc   = '0;
        case (bus.Opcode)
            OP_AND:  nx_res = bus.A & bus.B;
            OP_OR:   nx_res = bus.A | bus.B;
            OP_XOR:  nx_res = bus.A ^ bus.B;
            OP_NOT:  nx_res = ~bus.A;
            OP_ADD, OP_ADDC: begin
                nx_res        = add_x[WIDTH-1:0];
                nx_flg[FLG_C] = add_x[WIDTH];
                nx_flg[FLG_F] = add_ovf;
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                nx_res        = sub_x[WIDTH-1:0];
                nx_flg[FLG_C] = sub_x[WIDTH];
                nx_flg[FLG_F] = sub_ovf;
                nx_flg[FLG_L] = bus.A < bus.B;
                nx_flg[FLG_N] = $signed(bus.A) < $signed(bus.B);
                nx_wr         = (bus.Opcode != OP_CMP);
            end
            OP_TEST: begin
                nx_res = bus.A & bus.B;
                nx_wr  = 1'b0;
            end
            OP_LSH: begin
                nx_res        = lsh_x[WIDTH-1:0];
                nx_flg[FLG_C] = lsh_x[WIDTH];
            end
            OP_RSH: begin
                nx_res        = rsh_x[WIDTH:1];
                nx_flg[FLG_C] = rsh_x[0];
            end
            OP_ARSH: begin
                nx_res        = ash_x[WIDTH:1];
                nx_flg[FLG_C] = ash_x[0];
            end
            default: zen = 1'b0;
        endcase
        if (bus.Opcode inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDC, OP_TEST})
            nx_flg[FLG_N] = nx_res[M];
        zsrc          = nx_res;
        nx_flg[FLG_Z] = zen && (zsrc == '0);
    end

`ifdef ALU_MUL_EN
    state_t             state;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign bus.InReady = (state == ST_IDLE);
    assign accept      = bus.InValid && bus.InReady;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept && (bus.Opcode == OP_MUL)),
        .A       (bus.A),
        .B       (bus.B),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign bus.InReady = 1'b1;
    assign accept      = bus.InValid;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res    <= '0;
            res_hi <= '0;
            flg    <= '0;
            ovld   <= 1'b0;
`ifdef ALU_MUL_EN
            state  <= ST_IDLE;
`endif
        end else begin
            ovld <= 1'b0;
`ifdef ALU_MUL_EN
            case (state)
                ST_IDLE: if (accept) begin
                    if (bus.Opcode == OP_MUL) begin
                        state <= ST_MUL;
                    end else begin
                        if (nx_wr) begin
                            res    <= nx_res;
                            res_hi <= nx_hi;
                        end
                        flg  <= nx_flg;
                        ovld <= 1'b1;
                    end
                end
                ST_MUL: if (mul_done) state <= ST_DONE;
                ST_DONE: begin
                    res           <= mul_prod[WIDTH-1:0];
                    res_hi        <= mul_prod[2*WIDTH-1:WIDTH];
                    flg           <= '0;
                    flg[FLG_C]    <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                    flg[FLG_Z]    <= (mul_prod == '0);
                    ovld          <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
`else
            if (accept) begin
                if (nx_wr) begin
                    res    <= nx_res;
                    res_hi <= nx_hi;
                end
                flg  <= nx_flg;
                ovld <= 1'b1;
            end
`endif
        end
    end

    assign bus.OutValid = ovld;
    assign bus.Result   = res;
    assign bus.ResultHi = res_hi;
    assign bus.Carry    = flg[FLG_C];
    assign bus.Flag     = flg[FLG_F];
    assign bus.Low      = flg[FLG_L];
    assign bus.Negative = flg[FLG_N];
    assign bus.Zero     = flg[FLG_Z];
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=16; MUL steps depend on ALU_MUL_EN.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_pass = 0;

    alu_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // {Zero, Negative, Low, Flag, Carry}
    function automatic logic [4:0] flags();
        return {bus.Zero, bus.Negative, bus.Low, bus.Flag, bus.Carry};
    endfunction

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
        bus.InValid = 1'b1;
        bus.Opcode  = op;
        bus.A       = a;
        bus.B       = b;
        bus.CarryIn = cin;
        tick();
        bus.InValid = 1'b0;
        bus.CarryIn = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;
        bus.InValid = 1'b0;
        bus.Opcode  = '0;
        bus.A       = '0;
        bus.B       = '0;
        bus.CarryIn = 1'b0;
        reset_n     = 1'b0;
        tick();
        tick();
        chk("rst_result", bus.Result, 16'h0);
        chk("rst_hi", bus.ResultHi, 16'h0);
        chk("rst_flags", flags(), 5'b00000);
        chk("rst_ovalid", bus.OutValid, 1'b0);
        chk("rst_ready", bus.InReady, 1'b1);
        reset_n = 1'b1;
        tick();

        issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        chk("add_ovalid", bus.OutValid, 1'b1);
        chk("add_result", bus.Result, 16'h8000);
        chk("add_flags", flags(), 5'b01010);
        tick();
        chk("add_pulse", bus.OutValid, 1'b0);
        chk("add_hold", bus.Result, 16'h8000);

        issue(OP_ADDC, 16'hFFFF, 16'h0000, 1'b1);
        chk("addc_result", bus.Result, 16'h0000);
        chk("addc_flags", flags(), 5'b10001);

        // SUB, CMP, TEST accepted on consecutive edges
        issue(OP_SUB, 16'h0003, 16'h0005, 1'b0);
        chk("sub_result", bus.Result, 16'hFFFE);
        chk("sub_flags", flags(), 5'b01101);
        issue(OP_CMP, 16'h8000, 16'h0001, 1'b0);
        chk("cmp_ovalid", bus.OutValid, 1'b1);
        chk("cmp_result", bus.Result, 16'hFFFE);
        chk("cmp_flags", flags(), 5'b01010);
        issue(OP_CMP, 16'h1234, 16'h1234, 1'b0);
        chk("cmp_eq_flags", flags(), 5'b10000);
        issue(OP_TEST, 16'h00F0, 16'h0F00, 1'b0);
        chk("test_result", bus.Result, 16'hFFFE);
        chk("test_flags", flags(), 5'b10000);

        issue(OP_SUBC, 16'h0005, 16'h0005, 1'b1);
        chk("subc_result", bus.Result, 16'hFFFF);
        chk("subc_flags", flags(), 5'b00001);
        issue(OP_XOR, 16'hFF00, 16'h0FF0, 1'b0);
        chk("xor_result", bus.Result, 16'hF0F0);
        chk("xor_flags", flags(), 5'b01000);
        issue(OP_NOT, 16'hFFFF, 16'h0000, 1'b0);
        chk("not_result", bus.Result, 16'h0000);
        chk("not_flags", flags(), 5'b10000);
        issue(OP_OR, 16'h0F00, 16'h00F0, 1'b0);
        chk("or_result", bus.Result, 16'h0FF0);

        issue(OP_ARSH, 16'h8000, 16'h0004, 1'b0);
        chk("arsh_result", bus.Result, 16'hF800);
        chk("arsh_flags", flags(), 5'b00000);
        issue(OP_LSH, 16'h0001, 16'h0010, 1'b0);
        chk("lsh16_result", bus.Result, 16'h0000);
        chk("lsh16_zero", bus.Zero, 1'b1);
        issue(OP_RSH, 16'h0003, 16'h0001, 1'b0);
        chk("rsh_result", bus.Result, 16'h0001);
        chk("rsh_flags", flags(), 5'b00001);
        issue(OP_LSH, 16'h8001, 16'h0001, 1'b0);
        chk("lsh1_result", bus.Result, 16'h0002);
        chk("lsh1_flags", flags(), 5'b00001);
        issue(OP_ARSH, 16'h8001, 16'h0014, 1'b0);
        chk("arsh_big_result", bus.Result, 16'hFFFF);
        issue(OP_RSH, 16'hFFFF, 16'h0000, 1'b0);
        chk("rsh0_result", bus.Result, 16'hFFFF);
        chk("rsh0_flags", flags(), 5'b00000);

        issue(4'd14, 16'h1234, 16'h5678, 1'b1);
        chk("undef_ovalid", bus.OutValid, 1'b1);
        chk("undef_result", bus.Result, 16'h0000);
        chk("undef_flags", flags(), 5'b00000);

`ifdef ALU_MUL_EN
        issue(OP_MUL, 16'h1234, 16'h0100, 1'b0);
        chk("mul_ready_low", bus.InReady, 1'b0);
        n = 0;
        seen = 1'b0;
        while (!bus.InReady && n < 40) begin
            if (bus.OutValid) seen = 1'b1;
            bus.InValid = (n == 3);
            bus.Opcode  = OP_ADD;
            bus.A       = 16'h0001;
            bus.B       = 16'h0001;
            tick();
            n++;
        end
        bus.InValid = 1'b0;
        chk("mul_busy_cycles", n, 17);
        chk("mul_no_early_ovalid", seen, 1'b0);
        chk("mul_ovalid", bus.OutValid, 1'b1);
        chk("mul_hi", bus.ResultHi, 16'h0012);
        chk("mul_lo", bus.Result, 16'h3400);
        chk("mul_flags", flags(), 5'b00001);
        tick();
        chk("mul_pulse", bus.OutValid, 1'b0);

        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
        n = 0;
        while (!bus.OutValid && n < 40) begin
            tick();
            n++;
        end
        chk("mul_ff_latency", n, 17);
        chk("mul_ff_hi", bus.ResultHi, 16'hFFFE);
        chk("mul_ff_lo", bus.Result, 16'h0001);

        // reset lands on the fifth edge after the MUL was accepted
        issue(OP_MUL, 16'h0003, 16'h0005, 1'b0);
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
`else
        issue(OP_ADD, 16'h0002, 16'h0003, 1'b0);
        issue(OP_MUL, 16'h1234, 16'h0100, 1'b0);
        chk("mul_off_ovalid", bus.OutValid, 1'b1);
        chk("mul_off_ready", bus.InReady, 1'b1);
        chk("mul_off_result", bus.Result, 16'h0000);
        chk("mul_off_flags", flags(), 5'b00000);
        issue(OP_ADD, 16'h1111, 16'h2222, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
`endif
        chk("abort_result", bus.Result, 16'h0000);
        chk("abort_hi", bus.ResultHi, 16'h0000);
        chk("abort_flags", flags(), 5'b00000);
        chk("abort_ovalid", bus.OutValid, 1'b0);
        chk("abort_ready", bus.InReady, 1'b1);
        seen = 1'b0;
        repeat (20) begin
            if (bus.OutValid) seen = 1'b1;
            tick();
        end
        chk("abort_quiet", seen, 1'b0);

        issue(OP_ADD, 16'h0002, 16'h0003, 1'b0);
        chk("post_ovalid", bus.OutValid, 1'b1);
        chk("post_result", bus.Result, 16'h0005);
        chk("post_flags", flags(), 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
